// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: operand width, M-extension funct3 codes,
// and the state/mode encodings used by the iterative multiply/divide unit.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    typedef enum logic {
        MD_MODE_MUL = 1'b0,
        MD_MODE_DIV = 1'b1
    } md_mode_e;

endpackage

// File: rtl/riscv_muldiv_iter.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Accumulator layout:
//   multiply: {partial high word, multiplier bits still to consume}
//   divide:   {remainder, dividend bits still to consume / quotient bits}
module riscv_muldiv_iter
    import riscv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  md_mode_e          mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] rem_diff;

    // XLEN+1-bit adder for the shift-add step
    assign add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    // remainder shifted left with the next dividend bit; the top bit is the guard
    assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    // the remainder is always below the divisor, so bit XLEN acts as the borrow
    assign rem_diff  = rem_shift - {1'b0, operand};

    // Select the shift-add or restoring-subtract result
    always_comb begin
        acc_next = acc;
        if (mode == MD_MODE_MUL) begin
            if (acc[0]) begin
                acc_next = {add_sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
            end
        end else begin
            if (!rem_diff[XLEN]) begin
                acc_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit. Works on operand magnitudes for
// 32 cycles, fixes up signs and special cases, then emits a single-cycle
// register-file write-back.
module riscv_muldiv #(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            we,
    output logic            done,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd
);

    import riscv_pkg::*;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state;
    logic [4:0]        cnt;
    logic [2:0]        f3_r;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   rs1_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2*XLEN-1:0] acc;
    logic              spec_zero;
    logic              spec_ovf;
    logic [4:0]        wa_r;
    logic [XLEN-1:0]   wd_r;

    logic              div_op;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              zero_in;
    logic              ovf_in;
    md_mode_e          mode;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remv;
    logic [XLEN-1:0]   res;

    // Two's complement negation at operand width
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of the full product
    function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] x);
        return ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Decode signedness and special cases from the request operands
    always_comb begin
        div_op   = funct3[2];
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_mag    = a_neg ? neg_x(rs1) : rs1;
        b_mag    = b_neg ? neg_x(rs2) : rs2;
        zero_in  = div_op && (rs2 == '0);
        ovf_in   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1 == MOST_NEG) && (rs2 == '1);
    end

    assign mode = f3_r[2] ? MD_MODE_DIV : MD_MODE_MUL;

    riscv_muldiv_iter u_iter (
        .acc      (acc),
        .operand  (opnd_r),
        .mode     (mode),
        .acc_next (acc_next)
    );

    // Sign fix-up, result selection and forced special-case results
    always_comb begin
        prod = (sign_a ^ sign_b) ? neg_p(acc) : acc;
        quot = (sign_a ^ sign_b) ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0];
        remv = sign_a ? neg_x(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        case (f3_r)
            F3_MUL:                        res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               res = quot;
            default:                       res = remv;
        endcase
        if (spec_zero) begin
            res = f3_r[1] ? rs1_r : '1;
        end else if (spec_ovf) begin
            res = f3_r[1] ? '0 : rs1_r;
        end
    end

    // Control FSM with operand latches, iteration counter and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            f3_r      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            rs1_r     <= '0;
            opnd_r    <= '0;
            acc       <= '0;
            spec_zero <= 1'b0;
            spec_ovf  <= 1'b0;
            wa_r      <= '0;
            wd_r      <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && !kill) begin
                        f3_r      <= funct3;
                        rs1_r     <= rs1;
                        wa_r      <= rd_in;
                        sign_a    <= a_neg;
                        sign_b    <= b_neg;
                        // multiply consumes rs2 bits, divide consumes rs1 bits
                        acc       <= {{XLEN{1'b0}}, (div_op ? a_mag : b_mag)};
                        opnd_r    <= div_op ? b_mag : a_mag;
                        spec_zero <= zero_in;
                        spec_ovf  <= ovf_in;
                        cnt       <= '0;
                        state     <= (FAST_SPEC && (zero_in || ovf_in)) ? MD_FIX : MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (kill) begin
                        state <= MD_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    if (kill) begin
                        state <= MD_IDLE;
                    end else begin
                        wd_r  <= res;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != MD_IDLE);
    // a flush during the completion cycle masks the strobe in that same cycle
    assign done = (state == MD_DONE) && !kill;
    assign we   = done && (wa_r != 5'd0);
    assign wa   = wa_r;
    assign wd   = wd_r;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv: a FAST_SPEC=1 and a FAST_SPEC=0 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_riscv_muldiv;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;

    logic        busy_f, we_f, done_f;
    logic [4:0]  wa_f;
    logic [31:0] wd_f;
    logic        busy_s, we_s, done_s;
    logic [4:0]  wa_s;
    logic [31:0] wd_s;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .busy(busy_f), .we(we_f), .done(done_f), .wa(wa_f), .wd(wd_f)
    );

    riscv_muldiv #(.XLEN(32), .FAST_SPEC(1'b0)) dut_slow (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .busy(busy_s), .we(we_s), .done(done_s), .wa(wa_s), .wd(wd_s)
    );

    // start is sampled at the next rising edge (edge k), then dropped
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        funct3 = f; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Latency is reported as the cycle number k+N in which done is first high (0 = never)
    task automatic wait_both(output int lf, output logic [31:0] wf, output logic wef,
                             output logic [4:0] waf, output int ls, output logic [31:0] ws,
                             output logic df_after);
        lf = 0; ls = 0; wf = '0; wef = 1'b0; waf = '0; ws = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (lf == 0 && done_f) begin lf = i + 1; wf = wd_f; wef = we_f; waf = wa_f; end
            if (ls == 0 && done_s) begin ls = i + 1; ws = wd_s; end
            if (lf != 0 && ls != 0) break;
        end
        @(posedge clk); #1;
        df_after = done_f;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (busy_f !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy_f); end
        nvec++; if (done_f !== 1'b0 || we_f !== 1'b0) begin nfail++; $display("FAIL reset_done_we: got %b/%b want 0/0", done_f, we_f); end
        nvec++; if (wa_f !== 5'd0 || wd_f !== 32'd0) begin nfail++; $display("FAIL reset_wa_wd: got %0d/%h want 0/0", wa_f, wd_f); end
        nvec++; if (busy_s !== 1'b0) begin nfail++; $display("FAIL reset_busy_slow: got %b want 0", busy_s); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        nvec++; if (busy_f !== 1'b0) begin nfail++; $display("FAIL idle_after_reset: got %b want 0", busy_f); end
    endtask

    task automatic test_mul();
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        issue(F3_MUL, 32'd7, 32'd6, 5'd5);
        nvec++; if (busy_f !== 1'b1) begin nfail++; $display("FAIL mul_busy: got %b want 1", busy_f); end
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 34) begin nfail++; $display("FAIL mul_latency: got %0d want 34", lf); end
        nvec++; if (wf !== 32'h0000002A) begin nfail++; $display("FAIL mul_wd: got %h want 0000002a", wf); end
        nvec++; if (wef !== 1'b1 || waf !== 5'd5) begin nfail++; $display("FAIL mul_we_wa: got %b/%0d want 1/5", wef, waf); end
        nvec++; if (ls !== 34 || ws !== 32'h0000002A) begin nfail++; $display("FAIL mul_slow: got %0d/%h want 34/0000002a", ls, ws); end
        nvec++; if (dfa !== 1'b0) begin nfail++; $display("FAIL mul_done_drop: got %b want 0", dfa); end
    endtask

    task automatic test_mulh();
        logic [2:0]  tf [4] = '{F3_MULH, F3_MULHSU, F3_MULHU, F3_MUL};
        logic [31:0] ta [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
        logic [31:0] tb [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005};
        logic [31:0] te [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF1};
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        for (int i = 0; i < 4; i++) begin
            issue(tf[i], ta[i], tb[i], 5'd10);
            wait_both(lf, wf, wef, waf, ls, ws, dfa);
            nvec++; if (wf !== te[i] || lf !== 34) begin nfail++; $display("FAIL mulh_%0d: got %h@%0d want %h@34", i, wf, lf, te[i]); end
            nvec++; if (ws !== te[i]) begin nfail++; $display("FAIL mulh_slow_%0d: got %h want %h", i, ws, te[i]); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  tf [6] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
        logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] tb [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] te [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        for (int i = 0; i < 6; i++) begin
            issue(tf[i], ta[i], tb[i], 5'd11);
            wait_both(lf, wf, wef, waf, ls, ws, dfa);
            nvec++; if (wf !== te[i] || lf !== 34) begin nfail++; $display("FAIL div_%0d: got %h@%0d want %h@34", i, wf, lf, te[i]); end
            nvec++; if (ws !== te[i]) begin nfail++; $display("FAIL div_slow_%0d: got %h want %h", i, ws, te[i]); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  tf [6] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM, F3_DIV, F3_REMU};
        logic [31:0] ta [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        logic [31:0] tb [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] te [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        for (int i = 0; i < 6; i++) begin
            issue(tf[i], ta[i], tb[i], 5'd12);
            wait_both(lf, wf, wef, waf, ls, ws, dfa);
            nvec++; if (wf !== te[i] || lf !== 2) begin nfail++; $display("FAIL spec_fast_%0d: got %h@%0d want %h@2", i, wf, lf, te[i]); end
            nvec++; if (ws !== te[i] || ls !== 34) begin nfail++; $display("FAIL spec_slow_%0d: got %h@%0d want %h@34", i, ws, ls, te[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        issue(F3_MUL, 32'd7, 32'd6, 5'd5);
        repeat (5) @(posedge clk);
        #1;
        // second request while busy must leave no trace
        funct3 = F3_MUL; rs1 = 32'd100; rs2 = 32'd100; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 28 || wf !== 32'h0000002A) begin nfail++; $display("FAIL busy_start: got %h@%0d want 0000002a@28", wf, lf); end
        nvec++; if (waf !== 5'd5) begin nfail++; $display("FAIL busy_start_wa: got %0d want 5", waf); end
        // accepted in the cycle right after done
        issue(F3_DIVU, 32'd100, 32'd7, 5'd7);
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 34 || wf !== 32'd14 || waf !== 5'd7) begin nfail++; $display("FAIL b2b: got %h@%0d wa %0d want 0000000e@34 wa 7", wf, lf, waf); end
    endtask

    task automatic test_kill();
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        issue(F3_MUL, 32'd7, 32'd6, 5'd5);
        repeat (8) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        nvec++; if (busy_f !== 1'b0 || busy_s !== 1'b0) begin nfail++; $display("FAIL kill_busy: got %b/%b want 0/0", busy_f, busy_s); end
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 0 || ls !== 0) begin nfail++; $display("FAIL kill_no_done: got %0d/%0d want 0/0", lf, ls); end
        issue(F3_DIVU, 32'd100, 32'd7, 5'd4);
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 34 || wf !== 32'd14 || wef !== 1'b1 || waf !== 5'd4) begin nfail++; $display("FAIL after_kill: got %h@%0d we %b wa %0d want 0000000e@34 we 1 wa 4", wf, lf, wef, waf); end
        // flush during the completion cycle
        issue(F3_DIVU, 32'd5, 32'd0, 5'd6);
        @(posedge clk); #1;
        nvec++; if (done_f !== 1'b1) begin nfail++; $display("FAIL kdone_pre: got %b want 1", done_f); end
        kill = 1'b1;
        #1;
        nvec++; if (done_f !== 1'b0 || we_f !== 1'b0) begin nfail++; $display("FAIL kdone_mask: got %b/%b want 0/0", done_f, we_f); end
        @(posedge clk); #1;
        kill = 1'b0;
        nvec++; if (busy_f !== 1'b0 || busy_s !== 1'b0) begin nfail++; $display("FAIL kdone_idle: got %b/%b want 0/0", busy_f, busy_s); end
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 0 || ls !== 0) begin nfail++; $display("FAIL kdone_no_done: got %0d/%0d want 0/0", lf, ls); end
        // start together with kill in IDLE is ignored
        kill = 1'b1;
        issue(F3_MUL, 32'd2, 32'd2, 5'd3);
        kill = 1'b0;
        nvec++; if (busy_f !== 1'b0 || busy_s !== 1'b0) begin nfail++; $display("FAIL kill_start: got %b/%b want 0/0", busy_f, busy_s); end
    endtask

    task automatic test_rd0_reset();
        int lf, ls; logic [31:0] wf, ws; logic wef, dfa; logic [4:0] waf;
        issue(F3_MUL, 32'd3, 32'd3, 5'd0);
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 34 || wf !== 32'd9) begin nfail++; $display("FAIL rd0_done: got %h@%0d want 00000009@34", wf, lf); end
        nvec++; if (wef !== 1'b0 || waf !== 5'd0) begin nfail++; $display("FAIL rd0_we: got %b/%0d want 0/0", wef, waf); end
        issue(F3_MUL, 32'd7, 32'd6, 5'd5);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        nvec++; if (busy_f !== 1'b0 || done_f !== 1'b0 || we_f !== 1'b0) begin nfail++; $display("FAIL areset_ctl: got %b/%b/%b want 0/0/0", busy_f, done_f, we_f); end
        nvec++; if (wd_f !== 32'd0 || wa_f !== 5'd0) begin nfail++; $display("FAIL areset_data: got %h/%0d want 0/0", wd_f, wa_f); end
        nvec++; if (busy_s !== 1'b0 || wd_s !== 32'd0) begin nfail++; $display("FAIL areset_slow: got %b/%h want 0/0", busy_s, wd_s); end
        @(negedge clk);
        reset = 1'b0;
        wait_both(lf, wf, wef, waf, ls, ws, dfa);
        nvec++; if (lf !== 0 || ls !== 0) begin nfail++; $display("FAIL areset_no_done: got %0d/%0d want 0/0", lf, ls); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_rd0_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
